// File: rtl/oven_pkg.sv
// Shared definitions for the oven mode controller: state codes, value width, ambient temperature.
package oven_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SET_TEMP = 2'd1,
      ST_BAKING   = 2'd2,
      ST_SET_TIME = 2'd3
   } oven_state_t;

   localparam int VAL_W = 10;
   localparam logic [VAL_W-1:0] AMBIENT_TEMP = 10'd65;

endpackage

// File: rtl/oven_idle_timer.sv
// Entry-screen inactivity timer: counts 1 Hz ticks while enabled and pulses o_expire
// for one clk on the tick that reaches IDLE_TIMEOUT.
module oven_idle_timer #(
   parameter int IDLE_TIMEOUT = 30
) (
   input  logic clk,
   input  logic reset,
   input  logic i_enable,
   input  logic i_clear,
   input  logic i_tick,
   output logic o_expire
);

   localparam int CW = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(IDLE_TIMEOUT - 1);

   logic [CW-1:0] r_count;
   logic          w_hit;

   // A press in the same clk as a tick suppresses the expiry and restarts the count.
   assign w_hit    = i_enable & ~i_clear & i_tick & (r_count == LAST);
   assign o_expire = w_hit;

   // Tick counter, held at zero whenever the owning screen is inactive.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= {CW{1'b0}};
      end else if (!i_enable || i_clear || w_hit) begin
         r_count <= {CW{1'b0}};
      end else if (i_tick) begin
         r_count <= r_count + CW'(1);
      end else begin
         r_count <= r_count;
      end
   end

endmodule

// File: rtl/oven_sequencer.sv
// Oven mode controller: button pulses -> state code, target temperature and timer entry.
// Optional door interlock enabled by defining OVEN_DOOR_INTERLOCK_EN.
module oven_sequencer
   import oven_pkg::*;
#(
   parameter int TEMP_MIN     = 150,
   parameter int TEMP_MAX     = 550,
   parameter int TEMP_DEFAULT = 350,
   parameter int TEMP_STEP    = 5,
   parameter int TIME_STEP    = 60,
   parameter int TIME_MAX     = 960,
   parameter int IDLE_TIMEOUT = 30
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_1hz,
   input  logic             btn_mode,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_start,
   input  logic             btn_cancel,
   input  logic             door_open,
   input  logic             cycle_done,
   output logic [1:0]       state,
   output logic [VAL_W-1:0] target_temp,
   output logic [VAL_W-1:0] timer_val,
   output logic             done_pulse,
   output logic             alarm
);

   localparam int EW = VAL_W + 1;
   localparam logic [EW-1:0] L_TEMP_MIN  = EW'(TEMP_MIN);
   localparam logic [EW-1:0] L_TEMP_MAX  = EW'(TEMP_MAX);
   localparam logic [EW-1:0] L_TEMP_STEP = EW'(TEMP_STEP);
   localparam logic [EW-1:0] L_TIME_STEP = EW'(TIME_STEP);
   localparam logic [EW-1:0] L_TIME_MAX  = EW'(TIME_MAX);

   oven_state_t      r_state, w_state_nxt;
   logic [VAL_W-1:0] r_temp, w_temp_nxt, r_timer, w_timer_nxt;
   logic             r_done, w_done_nxt;
   logic             w_any_press, w_expire, w_entry, w_abort, w_start_ok;
   logic             w_up_only, w_down_only;
   logic [EW-1:0]    w_temp_ext, w_temp_sum, w_temp_diff;
   logic [EW-1:0]    w_timer_ext, w_timer_sum, w_timer_diff;
   logic [VAL_W-1:0] w_temp_up, w_temp_dn, w_timer_up, w_timer_dn;

   assign w_any_press = btn_mode | btn_up | btn_down | btn_start | btn_cancel;
   assign w_up_only   = btn_up & ~btn_down;
   assign w_down_only = btn_down & ~btn_up;
   assign w_entry     = (r_state == ST_SET_TEMP) || (r_state == ST_SET_TIME);

   // Step arithmetic is one bit wider than the values so clamping sees the true result.
   assign w_temp_ext   = {1'b0, r_temp};
   assign w_temp_sum   = w_temp_ext + L_TEMP_STEP;
   assign w_temp_diff  = w_temp_ext - L_TEMP_STEP;
   assign w_temp_up    = (w_temp_sum > L_TEMP_MAX) ? L_TEMP_MAX[VAL_W-1:0] : w_temp_sum[VAL_W-1:0];
   assign w_temp_dn    = (w_temp_ext < (L_TEMP_MIN + L_TEMP_STEP)) ? L_TEMP_MIN[VAL_W-1:0]
                                                                   : w_temp_diff[VAL_W-1:0];
   assign w_timer_ext  = {1'b0, r_timer};
   assign w_timer_sum  = w_timer_ext + L_TIME_STEP;
   assign w_timer_diff = w_timer_ext - L_TIME_STEP;
   assign w_timer_up   = (w_timer_sum > L_TIME_MAX) ? L_TIME_MAX[VAL_W-1:0] : w_timer_sum[VAL_W-1:0];
   assign w_timer_dn   = (w_timer_ext < L_TIME_STEP) ? {VAL_W{1'b0}} : w_timer_diff[VAL_W-1:0];

   oven_idle_timer #(
      .IDLE_TIMEOUT (IDLE_TIMEOUT)
   ) u_idle_timer (
      .clk      (clk),
      .reset    (reset),
      .i_enable (w_entry),
      .i_clear  (w_any_press),
      .i_tick   (tick_1hz),
      .o_expire (w_expire)
   );

`ifdef OVEN_DOOR_INTERLOCK_EN
   logic r_door_q, r_alarm;

   assign w_abort    = (r_state == ST_BAKING) & door_open & ~r_door_q;
   assign w_start_ok = ~door_open;
   assign alarm      = r_alarm;

   // Door edge history and alarm latch; a new abort outranks a simultaneous clearing press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_door_q <= 1'b0;
         r_alarm  <= 1'b0;
      end else begin
         r_door_q <= door_open;
         if (w_abort) begin
            r_alarm <= 1'b1;
         end else if (w_any_press) begin
            r_alarm <= 1'b0;
         end else begin
            r_alarm <= r_alarm;
         end
      end
   end
`else
   logic w_unused_door;

   assign w_unused_door = door_open;
   assign w_abort       = 1'b0;
   assign w_start_ok    = 1'b1;
   assign alarm         = 1'b0;
`endif

   // Next-state and value update; press priority is cancel > mode > start > up > down.
   always_comb begin
      w_state_nxt = r_state;
      w_temp_nxt  = r_temp;
      w_timer_nxt = r_timer;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!btn_cancel && btn_mode) begin
               w_state_nxt = ST_SET_TEMP;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SET_TEMP: begin
            if (btn_cancel) begin
               w_state_nxt = ST_IDLE;
            end else if (btn_mode) begin
               w_state_nxt = ST_SET_TIME;
            end else if (btn_start) begin
               w_state_nxt = ST_SET_TEMP;
            end else if (w_up_only) begin
               w_temp_nxt = w_temp_up;
            end else if (w_down_only) begin
               w_temp_nxt = w_temp_dn;
            end else if (w_expire) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_SET_TEMP;
            end
         end
         ST_SET_TIME: begin
            if (btn_cancel) begin
               w_state_nxt = ST_IDLE;
            end else if (btn_mode) begin
               w_state_nxt = ST_SET_TEMP;
            end else if (btn_start) begin
               if ((r_timer != {VAL_W{1'b0}}) && w_start_ok) begin
                  w_state_nxt = ST_BAKING;
               end else begin
                  w_state_nxt = ST_SET_TIME;
               end
            end else if (w_up_only) begin
               w_timer_nxt = w_timer_up;
            end else if (w_down_only) begin
               w_timer_nxt = w_timer_dn;
            end else if (w_expire) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_SET_TIME;
            end
         end
         ST_BAKING: begin
            if (w_abort || btn_cancel) begin
               w_state_nxt = ST_IDLE;
            end else if (cycle_done) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = ST_BAKING;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_temp  <= VAL_W'(TEMP_DEFAULT);
         r_timer <= {VAL_W{1'b0}};
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_temp  <= w_temp_nxt;
         r_timer <= w_timer_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign state       = r_state;
   assign target_temp = r_temp;
   assign timer_val   = r_timer;
   assign done_pulse  = r_done;

endmodule

// File: tb/tb_oven_sequencer.sv
// Directed scoreboard bench for oven_sequencer; interlock checks follow OVEN_DOOR_INTERLOCK_EN.
module tb_oven_sequencer;

   localparam logic [4:0] B_NONE   = 5'b00000;
   localparam logic [4:0] B_MODE   = 5'b00001;
   localparam logic [4:0] B_UP     = 5'b00010;
   localparam logic [4:0] B_DOWN   = 5'b00100;
   localparam logic [4:0] B_START  = 5'b01000;
   localparam logic [4:0] B_CANCEL = 5'b10000;

   typedef struct {
      string      tag;
      logic [1:0] st;
      logic [9:0] temp;
      logic [9:0] tmr;
      logic       dp;
      logic       al;
   } exp_t;

   logic       clk, reset, tick_1hz;
   logic       btn_mode, btn_up, btn_down, btn_start, btn_cancel;
   logic       door_open, cycle_done;
   logic [1:0] state;
   logic [9:0] target_temp, timer_val;
   logic       done_pulse, alarm;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   oven_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .tick_1hz    (tick_1hz),
      .btn_mode    (btn_mode),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .btn_start   (btn_start),
      .btn_cancel  (btn_cancel),
      .door_open   (door_open),
      .cycle_done  (cycle_done),
      .state       (state),
      .target_temp (target_temp),
      .timer_val   (timer_val),
      .done_pulse  (done_pulse),
      .alarm       (alarm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_exp(input string tag, input int st, input int temp, input int tmr,
                           input logic dp, input logic al);
      exp_t e;
      e.tag  = tag;
      e.st   = 2'(st);
      e.temp = 10'(temp);
      e.tmr  = 10'(tmr);
      e.dp   = dp;
      e.al   = al;
      exp_q.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      n_assert++;
      assert (exp_q.size() > 0) else begin
         n_fail++;
         $error("FAIL scoreboard_empty: got 0 entries, want at least 1");
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_assert++;
         assert (state === e.st) else begin
            n_fail++; $error("FAIL %s state: got %0d want %0d", e.tag, state, e.st);
         end
         n_assert++;
         assert (target_temp === e.temp) else begin
            n_fail++; $error("FAIL %s target_temp: got %0d want %0d", e.tag, target_temp, e.temp);
         end
         n_assert++;
         assert (timer_val === e.tmr) else begin
            n_fail++; $error("FAIL %s timer_val: got %0d want %0d", e.tag, timer_val, e.tmr);
         end
         n_assert++;
         assert (done_pulse === e.dp) else begin
            n_fail++; $error("FAIL %s done_pulse: got %b want %b", e.tag, done_pulse, e.dp);
         end
         n_assert++;
         assert (alarm === e.al) else begin
            n_fail++; $error("FAIL %s alarm: got %b want %b", e.tag, alarm, e.al);
         end
      end
   endtask

   // One clk with the given pulses, sampled 1 ns after the edge.
   task automatic cyc(input logic [4:0] b, input logic t, input logic cd);
      {btn_cancel, btn_start, btn_down, btn_up, btn_mode} = b;
      tick_1hz   = t;
      cycle_done = cd;
      @(posedge clk);
      #1;
      {btn_cancel, btn_start, btn_down, btn_up, btn_mode} = B_NONE;
      tick_1hz   = 1'b0;
      cycle_done = 1'b0;
   endtask

   task automatic step(input string tag, input logic [4:0] b, input logic t, input logic cd,
                       input int st, input int temp, input int tmr, input logic dp, input logic al);
      push_exp(tag, st, temp, tmr, dp, al);
      cyc(b, t, cd);
      check_out();
   endtask

   initial begin
      reset = 1'b1; tick_1hz = 1'b0; door_open = 1'b0; cycle_done = 1'b0;
      {btn_cancel, btn_start, btn_down, btn_up, btn_mode} = B_NONE;
      repeat (2) @(posedge clk);
      #1;
      push_exp("reset", 0, 350, 0, 1'b0, 1'b0);
      check_out();
      reset = 1'b0;

      step("mode_to_temp", B_MODE, 1'b0, 1'b0, 1, 350, 0, 1'b0, 1'b0);
      step("temp_up1", B_UP, 1'b0, 1'b0, 1, 355, 0, 1'b0, 1'b0);
      step("temp_up2", B_UP, 1'b0, 1'b0, 1, 360, 0, 1'b0, 1'b0);
      step("temp_up3", B_UP, 1'b0, 1'b0, 1, 365, 0, 1'b0, 1'b0);
      step("mode_to_time", B_MODE, 1'b0, 1'b0, 3, 365, 0, 1'b0, 1'b0);
      step("time_up1", B_UP, 1'b0, 1'b0, 3, 365, 60, 1'b0, 1'b0);
      step("time_up2", B_UP, 1'b0, 1'b0, 3, 365, 120, 1'b0, 1'b0);
      step("time_updown", B_UP | B_DOWN, 1'b0, 1'b0, 3, 365, 120, 1'b0, 1'b0);
      step("mode_back_temp", B_MODE, 1'b0, 1'b0, 1, 365, 120, 1'b0, 1'b0);

      for (int i = 1; i <= 36; i++) step("temp_climb", B_UP, 1'b0, 1'b0, 1, 365 + 5 * i, 120, 1'b0, 1'b0);
      step("temp_to_max", B_UP, 1'b0, 1'b0, 1, 550, 120, 1'b0, 1'b0);
      step("temp_sat_max", B_UP, 1'b0, 1'b0, 1, 550, 120, 1'b0, 1'b0);
      for (int i = 1; i <= 80; i++) step("temp_fall", B_DOWN, 1'b0, 1'b0, 1, 550 - 5 * i, 120, 1'b0, 1'b0);
      step("temp_sat_min", B_DOWN, 1'b0, 1'b0, 1, 150, 120, 1'b0, 1'b0);
      step("start_in_temp", B_START, 1'b0, 1'b0, 1, 150, 120, 1'b0, 1'b0);

      step("mode_to_time2", B_MODE, 1'b0, 1'b0, 3, 150, 120, 1'b0, 1'b0);
      step("time_dn1", B_DOWN, 1'b0, 1'b0, 3, 150, 60, 1'b0, 1'b0);
      step("time_dn2", B_DOWN, 1'b0, 1'b0, 3, 150, 0, 1'b0, 1'b0);
      step("time_sat_zero", B_DOWN, 1'b0, 1'b0, 3, 150, 0, 1'b0, 1'b0);
      step("start_zero_timer", B_START, 1'b0, 1'b0, 3, 150, 0, 1'b0, 1'b0);
      for (int i = 1; i <= 16; i++) step("time_climb", B_UP, 1'b0, 1'b0, 3, 150, 60 * i, 1'b0, 1'b0);
      step("time_sat_max", B_UP, 1'b0, 1'b0, 3, 150, 960, 1'b0, 1'b0);
      for (int i = 1; i <= 14; i++) step("time_fall", B_DOWN, 1'b0, 1'b0, 3, 150, 960 - 60 * i, 1'b0, 1'b0);

      step("start_bake", B_START, 1'b0, 1'b0, 2, 150, 120, 1'b0, 1'b0);
      step("bake_up_frozen", B_UP, 1'b0, 1'b0, 2, 150, 120, 1'b0, 1'b0);
      step("bake_down_frozen", B_DOWN, 1'b0, 1'b0, 2, 150, 120, 1'b0, 1'b0);
      step("bake_mode_ignored", B_MODE, 1'b0, 1'b0, 2, 150, 120, 1'b0, 1'b0);
      step("bake_done", B_NONE, 1'b0, 1'b1, 0, 150, 120, 1'b1, 1'b0);
      step("done_one_clk", B_NONE, 1'b0, 1'b1, 0, 150, 120, 1'b0, 1'b0);
      step("idle_quiet", B_NONE, 1'b0, 1'b0, 0, 150, 120, 1'b0, 1'b0);
      step("idle_up_ignored", B_UP, 1'b0, 1'b0, 0, 150, 120, 1'b0, 1'b0);
      step("idle_start_ignored", B_START, 1'b0, 1'b0, 0, 150, 120, 1'b0, 1'b0);

      step("to_temp_timeout", B_MODE, 1'b0, 1'b0, 1, 150, 120, 1'b0, 1'b0);
      for (int i = 1; i <= 28; i++) begin
         step("tick_pre", B_NONE, 1'b1, 1'b0, 1, 150, 120, 1'b0, 1'b0);
         step("gap_pre", B_NONE, 1'b0, 1'b0, 1, 150, 120, 1'b0, 1'b0);
      end
      step("tick29_press", B_UP, 1'b1, 1'b0, 1, 155, 120, 1'b0, 1'b0);
      for (int i = 1; i <= 29; i++) begin
         step("tick_post", B_NONE, 1'b1, 1'b0, 1, 155, 120, 1'b0, 1'b0);
         step("gap_post", B_NONE, 1'b0, 1'b0, 1, 155, 120, 1'b0, 1'b0);
      end
      step("timeout_exit", B_NONE, 1'b1, 1'b0, 0, 155, 120, 1'b0, 1'b0);

      step("to_temp_cancel", B_MODE, 1'b0, 1'b0, 1, 155, 120, 1'b0, 1'b0);
      step("cancel_and_up", B_CANCEL | B_UP, 1'b0, 1'b0, 0, 155, 120, 1'b0, 1'b0);
      step("m1", B_MODE, 1'b0, 1'b0, 1, 155, 120, 1'b0, 1'b0);
      step("m2", B_MODE, 1'b0, 1'b0, 3, 155, 120, 1'b0, 1'b0);
      step("start2", B_START, 1'b0, 1'b0, 2, 155, 120, 1'b0, 1'b0);
      step("bake_cancel", B_CANCEL, 1'b0, 1'b1, 0, 155, 120, 1'b0, 1'b0);

      step("m3", B_MODE, 1'b0, 1'b0, 1, 155, 120, 1'b0, 1'b0);
      step("m4", B_MODE, 1'b0, 1'b0, 3, 155, 120, 1'b0, 1'b0);
      door_open = 1'b1;
`ifdef OVEN_DOOR_INTERLOCK_EN
      step("start_door_open", B_START, 1'b0, 1'b0, 3, 155, 120, 1'b0, 1'b0);
      door_open = 1'b0;
      step("start_door_shut", B_START, 1'b0, 1'b0, 2, 155, 120, 1'b0, 1'b0);
      door_open = 1'b1;
      step("door_abort", B_NONE, 1'b0, 1'b1, 0, 155, 120, 1'b0, 1'b1);
      step("alarm_holds", B_NONE, 1'b0, 1'b0, 0, 155, 120, 1'b0, 1'b1);
      step("alarm_clear", B_UP, 1'b0, 1'b0, 0, 155, 120, 1'b0, 1'b0);
      door_open = 1'b0;
      step("m5", B_MODE, 1'b0, 1'b0, 1, 155, 120, 1'b0, 1'b0);
      step("m6", B_MODE, 1'b0, 1'b0, 3, 155, 120, 1'b0, 1'b0);
      step("start3", B_START, 1'b0, 1'b0, 2, 155, 120, 1'b0, 1'b0);
`else
      step("start_door_ignored", B_START, 1'b0, 1'b0, 2, 155, 120, 1'b0, 1'b0);
      step("door_no_abort", B_NONE, 1'b0, 1'b0, 2, 155, 120, 1'b0, 1'b0);
      door_open = 1'b0;
`endif

      #2;
      reset = 1'b1;
      #1;
      push_exp("reset_mid_bake", 0, 350, 0, 1'b0, 1'b0);
      check_out();
      @(posedge clk);
      #1;
      reset = 1'b0;
      step("after_reset", B_NONE, 1'b0, 1'b0, 0, 350, 0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/oven_sequencer.md
# oven_sequencer

Top-level mode controller for the oven. It turns debounced front-panel button pulses into the 2-bit `state` code consumed by the baking datapath. It also owns the user-entered target temperature and timer value, and returns the oven to idle when a bake completes, is cancelled, or the user abandons an entry screen. It sits between the button debouncers and the baking, set-temp and set-time display blocks, and is paced by the shared 1 Hz tick.

## Interface
Parameters:
- TEMP_MIN, 150: lowest settable target temperature (°F).
- TEMP_MAX, 550: highest settable target temperature.
- TEMP_DEFAULT, 350: target temperature after reset.
- TEMP_STEP, 5: temperature change per up/down press.
- TIME_STEP, 60: timer change per up/down press, in seconds.
- TIME_MAX, 960: highest settable timer value, in seconds.
- IDLE_TIMEOUT, 30: seconds without a press before an entry screen exits.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick_1hz  in  1  one-clk pulse once per second.
- btn_mode, btn_up, btn_down, btn_start, btn_cancel  in  1 each  one-clk debounced press pulses.
- door_open  in  1  level; high while the door is open.
- cycle_done  in  1  level from the baking block: timer expired and oven cooled to ambient.
- state  out  2  0 = IDLE, 1 = SET_TEMP, 2 = BAKING, 3 = SET_TIME.
- target_temp  out  10  target temperature (°F), unsigned.
- timer_val  out  10  bake duration (s), unsigned.
- done_pulse  out  1  one-clk pulse when a bake ends normally.
- alarm  out  1  high after an interlock abort; cleared by the next button press.

## Operation
- All outputs are registered.
- Reset values: state = 0, target_temp = TEMP_DEFAULT, timer_val = 0, done_pulse = 0, alarm = 0, idle counter = 0.
- Press priority within one clk: cancel > mode > start > up > down. If up and down arrive together, there is no change.
- IDLE:
  - btn_mode → SET_TEMP.
  - All other presses are ignored except that they clear alarm.
- SET_TEMP:
  - up: target_temp += TEMP_STEP, saturating at TEMP_MAX.
  - down: target_temp -= TEMP_STEP, saturating at TEMP_MIN.
  - btn_mode → SET_TIME.
  - btn_cancel → IDLE.
- SET_TIME:
  - up: timer_val += TIME_STEP, saturating at TIME_MAX.
  - down: timer_val -= TIME_STEP, saturating at 0.
  - btn_mode → SET_TEMP.
  - btn_cancel → IDLE.
  - btn_start → BAKING, only when timer_val ≠ 0 (and the door is closed, see Configuration). Otherwise start is ignored.
- BAKING:
  - up, down and mode are ignored. target_temp and timer_val are frozen.
  - btn_cancel → IDLE, with no done_pulse.
  - cycle_done high → IDLE, with done_pulse for exactly one clk.
- Idle timeout: in SET_TEMP or SET_TIME, the counter increments on tick_1hz and clears on any button press or state change. When it reaches IDLE_TIMEOUT, the block goes to IDLE. Entered values are retained.
- Arithmetic is done at 11 bits and then clamped, so no 10-bit wrap-around is possible.
- Any press clears alarm.

## Timing
- A press in cycle N updates state, target_temp and timer_val at the clk edge ending cycle N (visible in cycle N+1).
- done_pulse is asserted in the same cycle state becomes 0, and deasserts the next cycle.
- cycle_done is sampled only in BAKING. If it is still high in the cycle after the exit to IDLE, it has no effect.
- A tick and a press in the same cycle: the press wins and the counter clears.
- Reset asserted mid-bake forces IDLE immediately (asynchronously); the entered values return to reset values.

## Configuration
- OVEN_DOOR_INTERLOCK_EN defined:
  - btn_start is ignored while door_open = 1.
  - door_open rising while in BAKING → IDLE next clk, alarm = 1, no done_pulse.
- OVEN_DOOR_INTERLOCK_EN undefined:
  - door_open is ignored entirely.
  - alarm is tied to 0.

## Structure
- Shared package oven_pkg holds:
  - state encodings ST_IDLE, ST_SET_TEMP, ST_BAKING, ST_SET_TIME (the existing 2-bit codes used by the other blocks);
  - a 10-bit value-width constant;
  - the ambient temperature constant 65.
- One sub-module, oven_idle_timer: tick-driven counter with clear, parameterised by IDLE_TIMEOUT, producing a one-clk expire pulse.
- Saturating step logic stays inline.

## Test plan
- Reset, then mode, up ×3 → state = 1, target_temp = 365. Then mode, up ×2 → state = 3, timer_val = 120.
- From target_temp = 545: up ×2 → 550. From timer_val = 0: down → 0. Start with timer_val = 0 → state stays 3.
- Start with timer_val = 120 → state = 2. Press up → values unchanged. Raise cycle_done → state = 0 and done_pulse high for 1 clk.
- In SET_TEMP, no presses for 30 ticks → state = 0 with target_temp retained. A press at tick 29 restarts the count.
- With OVEN_DOOR_INTERLOCK_EN: door_open during BAKING → state = 0, alarm = 1. Start with the door open is ignored. Any press → alarm = 0.
- Cancel and up in the same clk while in SET_TEMP → state = 0 and target_temp unchanged. Reset mid-bake → all outputs at their reset values.
